// File: rtl/k423_mem_pkg.sv
// Shared types and constants for the memory-stage data-memory controller.
package k423_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        LS_SIZE_BYTE = 2'd0,
        LS_SIZE_HALF = 2'd1,
        LS_SIZE_WORD = 2'd2
    } ls_size_e;

    localparam int DMEM_XLEN   = 32;
    localparam int DMEM_ADDR_W = 32;
    localparam int LANE_W      = 8;
    localparam int BE_W        = DMEM_XLEN / LANE_W;

    // Halves need an even address, words a 4-byte aligned one; bytes never trap.
    function automatic logic is_misaligned(input ls_size_e size, input logic [1:0] offset);
        logic mis;
        case (size)
            LS_SIZE_BYTE: mis = 1'b0;
            LS_SIZE_HALF: mis = offset[0];
            default:      mis = (offset != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/k423_mem_load_align.sv
// Combinational load aligner: moves the addressed lanes down to bit 0,
// truncates to the access size and sign- or zero-extends.
module k423_mem_load_align
    import k423_mem_pkg::*;
#(
    parameter int XLEN = DMEM_XLEN
) (
    input  logic [XLEN-1:0] i_rdata,
    input  logic [1:0]      i_offset,
    input  ls_size_e        i_size,
    input  logic            i_unsigned,
    output logic [XLEN-1:0] o_result
);

    logic [XLEN-1:0] w_shifted;
    logic            w_sign;

    // Lane shift, truncate and extend
    always_comb begin
        w_shifted = i_rdata >> {i_offset, 3'b000};
        w_sign    = 1'b0;
        o_result  = w_shifted;
        case (i_size)
            LS_SIZE_BYTE: begin
                w_sign   = ~i_unsigned & w_shifted[LANE_W-1];
                o_result = {{(XLEN-LANE_W){w_sign}}, w_shifted[LANE_W-1:0]};
            end
            LS_SIZE_HALF: begin
                w_sign   = ~i_unsigned & w_shifted[2*LANE_W-1];
                o_result = {{(XLEN-2*LANE_W){w_sign}}, w_shifted[2*LANE_W-1:0]};
            end
            default: begin
                w_sign   = 1'b0;
                o_result = w_shifted;
            end
        endcase
    end

endmodule

// File: rtl/k423_mem_dmem_ctrl.sv
// Memory-stage data-memory controller: one blocking load/store at a time,
// alignment trap, lane shifting towards the bus and load extension towards WB.
module k423_mem_dmem_ctrl
    import k423_mem_pkg::*;
#(
    parameter int XLEN   = DMEM_XLEN,
    parameter int ADDR_W = DMEM_ADDR_W
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   ex_vld_i,
    output logic                   ex_rdy_o,
    input  logic [ADDR_W-1:0]      ex_addr_i,
    input  logic [XLEN/LANE_W-1:0] ex_wen_i,
    input  logic [XLEN-1:0]        ex_wdata_i,
    input  logic                   ex_load_i,
    input  logic                   ex_load_unsigned_i,
    input  ls_size_e               ex_size_i,
    output logic                   dmem_req_vld_o,
    input  logic                   dmem_req_rdy_i,
    output logic [ADDR_W-1:0]      dmem_req_addr_o,
    output logic [XLEN/LANE_W-1:0] dmem_req_wen_o,
    output logic [XLEN-1:0]        dmem_req_wdata_o,
    input  logic                   dmem_rsp_vld_i,
    input  logic [XLEN-1:0]        dmem_rsp_rdata_i,
    output logic                   wb_vld_o,
    input  logic                   wb_rdy_i,
    output logic                   wb_load_o,
    output logic [XLEN-1:0]        wb_data_o,
    output logic                   wb_misalign_o
);

    localparam int LANES = XLEN / LANE_W;

    state_e             r_state;
    state_e             w_next_state;
    logic [1:0]         r_offset;
    ls_size_e           r_size;
    logic               r_unsigned;
    logic [ADDR_W-1:0]  r_req_addr;
    logic [LANES-1:0]   r_req_wen;
    logic [XLEN-1:0]    r_req_wdata;
    logic               r_wb_load;
    logic [XLEN-1:0]    r_wb_data;
    logic               r_misalign;
    logic               w_misalign;
    logic               w_accept;
    logic               w_rsp_fire;
    logic [XLEN-1:0]    w_load_result;

    assign w_misalign = is_misaligned(ex_size_i, ex_addr_i[1:0]);
    assign w_accept   = (r_state == ST_IDLE) & ex_vld_i;
    assign w_rsp_fire = (r_state == ST_RSP) & dmem_rsp_vld_i;

    k423_mem_load_align #(.XLEN(XLEN)) u_load_align (
        .i_rdata    (dmem_rsp_rdata_i),
        .i_offset   (r_offset),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_result   (w_load_result)
    );

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a non-zero byte enable marks a store, which completes on acceptance
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (ex_vld_i) w_next_state = w_misalign ? ST_DONE : ST_REQ;
                else          w_next_state = ST_IDLE;
            end
            ST_REQ: begin
                if (dmem_req_rdy_i) w_next_state = (|r_req_wen) ? ST_DONE : ST_RSP;
                else                w_next_state = ST_REQ;
            end
            ST_RSP: begin
                if (dmem_rsp_vld_i) w_next_state = ST_DONE;
                else                w_next_state = ST_RSP;
            end
            ST_DONE: begin
                if (wb_rdy_i) w_next_state = ST_IDLE;
                else          w_next_state = ST_DONE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from state; ready is held low while reset is asserted
    always_comb begin
        ex_rdy_o       = 1'b0;
        dmem_req_vld_o = 1'b0;
        wb_vld_o       = 1'b0;
        case (r_state)
            ST_IDLE: ex_rdy_o       = ~rst_i;
            ST_REQ:  dmem_req_vld_o = 1'b1;
            ST_RSP:  ex_rdy_o       = 1'b0;
            ST_DONE: wb_vld_o       = 1'b1;
            default: ex_rdy_o       = 1'b0;
        endcase
    end

    // Op capture: bus-side fields are shifted at accept so the request is driven straight from flops
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_offset    <= 2'b00;
            r_size      <= LS_SIZE_BYTE;
            r_unsigned  <= 1'b0;
            r_req_addr  <= '0;
            r_req_wen   <= '0;
            r_req_wdata <= '0;
            r_wb_load   <= 1'b0;
            r_wb_data   <= '0;
            r_misalign  <= 1'b0;
        end else if (w_accept) begin
            r_offset    <= ex_addr_i[1:0];
            r_size      <= ex_size_i;
            r_unsigned  <= ex_load_unsigned_i;
            r_req_addr  <= {ex_addr_i[ADDR_W-1:2], 2'b00};
            r_req_wen   <= ex_wen_i << ex_addr_i[1:0];
            r_req_wdata <= ex_wdata_i << {ex_addr_i[1:0], 3'b000};
            r_wb_load   <= ex_load_i & ~w_misalign;
            r_wb_data   <= '0;
            r_misalign  <= w_misalign;
        end else if (w_rsp_fire) begin
            r_wb_data   <= w_load_result;
        end
    end

    assign dmem_req_addr_o  = r_req_addr;
    assign dmem_req_wen_o   = r_req_wen;
    assign dmem_req_wdata_o = r_req_wdata;
    assign wb_load_o        = r_wb_load;
    assign wb_data_o        = r_wb_data;
    assign wb_misalign_o    = r_misalign;

endmodule
